// File: rtl/ps2_scancode_parser.sv
// PS/2 set-2 scan-code parser: folds E0/F0/E1 prefixed byte sequences into
// single key events (keyCode + make/brakee strobe), flagging broken sequences.
module ps2_scancode_parser #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_500_000,
  parameter logic [8:0]  PAUSE_CODE     = 9'h1E1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       dinNew,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakee,
  output logic       seqError
);

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  typedef struct packed {
    logic       make;
    logic       brk;
    logic       err;
    logic       load;
    logic [8:0] code;
  } event_t;

  state_t      state, nextState;
  logic [2:0]  skipCnt, skipNext;
  logic [23:0] idleCnt;
  logic        timeout;
  event_t      ev;

  function automatic logic isHousekeeping(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // A pending byte always beats an expiring timeout in the same cycle.
  assign timeout = (state != IDLE) && !dinNew &&
                   (idleCnt == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      skipCnt <= '0;
    end else begin
      state   <= nextState;
      skipCnt <= skipNext;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      idleCnt <= '0;
    else if (dinNew || timeout || state == IDLE)
      idleCnt <= '0;
    else if (idleCnt != '1)
      idleCnt <= idleCnt + 24'd1;
  end

  always_comb begin
    nextState = state;
    skipNext  = skipCnt;
    if (dinNew) begin
      unique case (state)
        IDLE: begin
          if (din == B_EXT)        nextState = EXT;
          else if (din == B_BRK)   nextState = BRK;
          else if (din == B_PAUSE) begin
            nextState = PAUSE;
            skipNext  = PAUSE_SKIP;
          end
        end
        EXT: begin
          if (din == B_BRK)        nextState = EXT_BRK;
          else if (din == B_PAUSE) begin
            nextState = PAUSE;
            skipNext  = PAUSE_SKIP;
          end else if (din != B_EXT) nextState = IDLE;
        end
        BRK: begin
          if (din == B_EXT)        nextState = EXT;
          else if (din != B_BRK)   nextState = IDLE;
        end
        EXT_BRK: nextState = IDLE;
        PAUSE: begin
          skipNext = skipCnt - 3'd1;
          if (skipCnt == 3'd1) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end else if (timeout) begin
      nextState = IDLE;
    end
  end

  // Next values of the registered event outputs.
  always_comb begin
    ev = '0;
    if (dinNew) begin
      unique case (state)
        IDLE: begin
          if (din != B_EXT && din != B_BRK && din != B_PAUSE &&
              !isHousekeeping(din)) begin
            ev.make = 1'b1;
            ev.load = 1'b1;
            ev.code = {1'b0, din};
          end
        end
        EXT: begin
          if (din == B_PAUSE) ev.err = 1'b1;
          else if (din != B_BRK && din != B_EXT) begin
            ev.make = 1'b1;
            ev.load = 1'b1;
            ev.code = {1'b1, din};
          end
        end
        BRK: begin
          if (din == B_EXT) ev.err = 1'b1;
          else if (din != B_BRK) begin
            ev.brk  = 1'b1;
            ev.load = 1'b1;
            ev.code = {1'b0, din};
          end
        end
        EXT_BRK: begin
          if (din == B_EXT || din == B_BRK) ev.err = 1'b1;
          else begin
            ev.brk  = 1'b1;
            ev.load = 1'b1;
            ev.code = {1'b1, din};
          end
        end
        PAUSE: begin
          if (skipCnt == 3'd1) begin
            ev.make = 1'b1;
            ev.load = 1'b1;
            ev.code = PAUSE_CODE;
          end
        end
        default: ev = '0;
      endcase
    end else if (timeout) begin
      ev.err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      keyCode  <= '0;
      make     <= 1'b0;
      brakee   <= 1'b0;
      seqError <= 1'b0;
    end else begin
      make     <= ev.make;
      brakee   <= ev.brk;
      seqError <= ev.err;
      if (ev.load) keyCode <= ev.code;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Bench for ps2_scancode_parser: directed scenarios with literal expectations,
// then random byte streams checked every cycle against a prefix-flag model.
module tb_ps2_scancode_parser;

  localparam logic [23:0] T_OUT = 24'd40;
  localparam logic [8:0]  PCODE = 9'h1E1;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dinNew = 1'b0;
  logic [8:0] keyCode;
  logic       make, brakee, seqError;

  int checks = 0;
  int errors = 0;
  bit cmpEn = 1'b0;

  ps2_scancode_parser #(.TIMEOUT_CYCLES(T_OUT), .PAUSE_CODE(PCODE)) dut (
    .clk(clk), .resetN(resetN), .din(din), .dinNew(dinNew),
    .keyCode(keyCode), .make(make), .brakee(brakee), .seqError(seqError)
  );

  always #5 clk = ~clk;

  // Model: "which prefixes are pending" plus bytes left to swallow for Pause.
  typedef struct packed {
    bit         ext;
    bit         brk;
    int         pauseLeft;
    int         gap;
    logic [8:0] code;
    bit         mk;
    bit         br;
    bit         er;
  } model_t;

  model_t mdl;

  function automatic bit hk(input logic [7:0] b);
    return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  function automatic model_t step(input model_t m, input logic dn, input logic [7:0] b);
    m.mk = 0; m.br = 0; m.er = 0;
    if (dn) begin
      m.gap = 0;
      if (m.pauseLeft > 0) begin
        m.pauseLeft--;
        if (m.pauseLeft == 0) begin m.code = PCODE; m.mk = 1; end
      end else if (!m.ext && !m.brk) begin
        if (b == 8'hE0) m.ext = 1;
        else if (b == 8'hF0) m.brk = 1;
        else if (b == 8'hE1) m.pauseLeft = 7;
        else if (!hk(b)) begin m.code = {1'b0, b}; m.mk = 1; end
      end else if (m.ext && !m.brk) begin
        if (b == 8'hF0) m.brk = 1;
        else if (b == 8'hE1) begin m.er = 1; m.ext = 0; m.pauseLeft = 7; end
        else if (b != 8'hE0) begin m.code = {1'b1, b}; m.mk = 1; m.ext = 0; end
      end else if (!m.ext && m.brk) begin
        if (b == 8'hE0) begin m.er = 1; m.brk = 0; m.ext = 1; end
        else if (b != 8'hF0) begin m.code = {1'b0, b}; m.br = 1; m.brk = 0; end
      end else begin
        if (b == 8'hE0 || b == 8'hF0) m.er = 1;
        else begin m.code = {1'b1, b}; m.br = 1; end
        m.ext = 0; m.brk = 0;
      end
    end else if (m.ext || m.brk || m.pauseLeft > 0) begin
      m.gap++;
      if (m.gap == int'(T_OUT)) begin
        m.er = 1; m.ext = 0; m.brk = 0; m.pauseLeft = 0; m.gap = 0;
      end
    end
    return m;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) mdl <= '0;
    else         mdl <= step(mdl, dinNew, din);
  end

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      chk("model.make",     {8'h0, make},     {8'h0, mdl.mk});
      chk("model.brakee",   {8'h0, brakee},   {8'h0, mdl.br});
      chk("model.seqError", {8'h0, seqError}, {8'h0, mdl.er});
      chk("model.keyCode",  keyCode,          mdl.code);
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte's
  // clock edge, followed by 'gap' further idle clocks.
  task automatic putByte(input logic [7:0] b, input int gap);
    din = b; dinNew = 1'b1;
    @(negedge clk);
    dinNew = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expEvent(input string nm, input bit mk, input bit br, input bit er,
                          input logic [8:0] code);
    chk({nm, ".make"},   {8'h0, make},     {8'h0, mk});
    chk({nm, ".brakee"}, {8'h0, brakee},   {8'h0, br});
    chk({nm, ".seqErr"}, {8'h0, seqError}, {8'h0, er});
    chk({nm, ".code"},   keyCode,          code);
  endtask

  logic [7:0] pauseSeq [8];
  logic [7:0] hkList [6];

  initial begin
    pauseSeq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    hkList   = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    repeat (2) @(negedge clk);
    expEvent("reset", 0, 0, 0, 9'h000);
    resetN = 1'b1;
    @(negedge clk);
    cmpEn = 1'b1;

    // housekeeping filtered, back-to-back bytes accepted
    putByte(8'hAA, 0); expEvent("hk.AA", 0, 0, 0, 9'h000);
    putByte(8'hFA, 0); expEvent("hk.FA", 0, 0, 0, 9'h000);
    putByte(8'h29, 0); expEvent("hk.29", 1, 0, 0, 9'h029);
    @(negedge clk);    expEvent("pulse1clk", 0, 0, 0, 9'h029);

    putByte(8'h1C, 1); putByte(8'hF0, 0);
    putByte(8'h1C, 0); expEvent("brk.1C", 0, 1, 0, 9'h01C);
    putByte(8'hE0, 0); putByte(8'h75, 0); expEvent("ext.75", 1, 0, 0, 9'h175);
    putByte(8'hE0, 0); putByte(8'hF0, 0); putByte(8'h75, 0);
    expEvent("extbrk.75", 0, 1, 0, 9'h175);

    for (int i = 0; i < 7; i++) putByte(pauseSeq[i], 0);
    expEvent("pause.7th", 0, 0, 0, 9'h175);
    putByte(pauseSeq[7], 0); expEvent("pause.8th", 1, 0, 0, 9'h1E1);
    putByte(8'h29, 0);       expEvent("after.pause", 1, 0, 0, 9'h029);

    putByte(8'hE0, 0); putByte(8'h12, 0); expEvent("prtsc.1", 1, 0, 0, 9'h112);
    putByte(8'hE0, 0); putByte(8'h7C, 0); expEvent("prtsc.2", 1, 0, 0, 9'h17C);

    // stalled E0 prefix
    putByte(8'hE0, 0);
    repeat (int'(T_OUT) - 1) @(negedge clk);
    expEvent("tmo.early", 0, 0, 0, 9'h17C);
    @(negedge clk);
    expEvent("tmo.fire", 0, 0, 1, 9'h17C);
    putByte(8'h29, 0); expEvent("tmo.next", 1, 0, 0, 9'h029);

    putByte(8'hF0, 0); putByte(8'hE0, 0); expEvent("brk.E0err", 0, 0, 1, 9'h029);
    putByte(8'h11, 0); expEvent("brk.E0ext", 1, 0, 0, 9'h111);

    // reset mid-sequence drops outputs asynchronously
    putByte(8'h1C, 0); putByte(8'hF0, 0);
    cmpEn = 1'b0;
    resetN = 1'b0; #1;
    expEvent("rst.async", 0, 0, 0, 9'h000);
    @(negedge clk); resetN = 1'b1; @(negedge clk);
    cmpEn = 1'b1;
    putByte(8'h1C, 0); expEvent("rst.after", 1, 0, 0, 9'h01C);

    // random streams: prefixes, housekeeping, codes, and gaps near the timeout
    for (int n = 0; n < 3000; n++) begin
      int sel;
      int gap;
      logic [7:0] b;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hE1;
        5:       b = hkList[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      gap = $urandom_range(0, 99);
      if (gap < 60)      gap = 0;
      else if (gap < 94) gap = $urandom_range(1, 3);
      else               gap = $urandom_range(int'(T_OUT) - 2, int'(T_OUT) + 2);
      putByte(b, gap);
      if (n == 1500) begin
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
      end
    end
    repeat (int'(T_OUT) + 2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
